id_issue_queue: RTL and testbench

//  Parametrised successor to the combinational decode stage. Buffers fetched instructions in a DEPTH-entry FIFO,

---
 rtl/id_issue_queue.sv | 227 ++++++++++++++++++++++
 tb/tb_id_issue_queue.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_issue_queue.sv
// Decode/issue stage: DEPTH-entry instruction FIFO, head decode, load-use scoreboard, registered issue slot.
// Optional JAL early redirect is enabled by defining ID_JAL_REDIRECT_EN.
module id_issue_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4,
   parameter int NREG  = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       inst_valid_i,
   input  logic [31:0]                inst_i,
   input  logic [XLEN-1:0]            pc_i,
   output logic                       inst_ready_o,
   input  logic                       flush_i,
   input  logic                       ld_done_i,
   input  logic [4:0]                 ld_done_addr_i,
   output logic                       issue_valid_o,
   input  logic                       issue_ready_i,
   output logic [3:0]                 opclass_o,
   output logic [2:0]                 funct3_o,
   output logic                       alt_o,
   output logic [4:0]                 rs1_o,
   output logic [4:0]                 rs2_o,
   output logic [4:0]                 rd_o,
   output logic                       wreg_o,
   output logic [XLEN-1:0]            imm_o,
   output logic [XLEN-1:0]            pc_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       redirect_valid_o,
   output logic [XLEN-1:0]            redirect_pc_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   localparam logic [3:0] OC_NOP    = 4'd0;
   localparam logic [3:0] OC_LUI    = 4'd1;
   localparam logic [3:0] OC_AUIPC  = 4'd2;
   localparam logic [3:0] OC_OPIMM  = 4'd3;
   localparam logic [3:0] OC_OP     = 4'd4;
   localparam logic [3:0] OC_LOAD   = 4'd5;
   localparam logic [3:0] OC_STORE  = 4'd6;
   localparam logic [3:0] OC_JAL    = 4'd7;
   localparam logic [3:0] OC_JALR   = 4'd8;
   localparam logic [3:0] OC_BRANCH = 4'd9;
   localparam logic [3:0] OC_ILL    = 4'd15;

   logic [31:0]     q_inst [DEPTH];
   logic [XLEN-1:0] q_pc   [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [NREG-1:0] pend, pend_next, set_mask, clr_mask;

   logic [31:0]     head_inst;
   logic [XLEN-1:0] head_pc;
   logic            head_valid, hazard, load, push, jal_redir;

   logic [3:0]      d_opc;
   logic [4:0]      d_rs1, d_rs2, d_rd;
   logic [31:0]     imm32;
   logic [XLEN-1:0] d_imm;

   assign head_inst    = q_inst[rd_ptr];
   assign head_pc      = q_pc[rd_ptr];
   assign head_valid   = (count_o != '0);
   assign inst_ready_o = (count_o != FULL_CNT);

   always_comb begin
      d_opc = OC_ILL;
      d_rs1 = '0;
      d_rs2 = '0;
      d_rd  = '0;
      imm32 = '0;
      case (head_inst[6:0])
         7'h37: begin d_opc = OC_LUI;   d_rd = head_inst[11:7]; imm32 = {head_inst[31:12], 12'b0}; end
         7'h17: begin d_opc = OC_AUIPC; d_rd = head_inst[11:7]; imm32 = {head_inst[31:12], 12'b0}; end
         7'h13: begin
            if (head_inst == 32'h0000_0013) begin
               d_opc = OC_NOP;
            end else begin
               d_opc = OC_OPIMM;
               d_rs1 = head_inst[19:15];
               d_rd  = head_inst[11:7];
               // shift-immediates carry a zero-extended shamt, not the funct7 bits
               if (head_inst[13:12] == 2'b01) imm32 = {27'b0, head_inst[24:20]};
               else                           imm32 = {{20{head_inst[31]}}, head_inst[31:20]};
            end
         end
         7'h33: begin
            d_opc = OC_OP;
            d_rs1 = head_inst[19:15];
            d_rs2 = head_inst[24:20];
            d_rd  = head_inst[11:7];
         end
         7'h03: begin
            d_opc = OC_LOAD;
            d_rs1 = head_inst[19:15];
            d_rd  = head_inst[11:7];
            imm32 = {{20{head_inst[31]}}, head_inst[31:20]};
         end
         7'h23: begin
            d_opc = OC_STORE;
            d_rs1 = head_inst[19:15];
            d_rs2 = head_inst[24:20];
            imm32 = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
         end
         7'h6f: begin
            d_opc = OC_JAL;
            d_rd  = head_inst[11:7];
            imm32 = {{11{head_inst[31]}}, head_inst[31], head_inst[19:12], head_inst[20],
                     head_inst[30:21], 1'b0};
         end
         7'h67: begin
            d_opc = OC_JALR;
            d_rs1 = head_inst[19:15];
            d_rd  = head_inst[11:7];
            imm32 = {{20{head_inst[31]}}, head_inst[31:20]};
         end
         7'h63: begin
            d_opc = OC_BRANCH;
            d_rs1 = head_inst[19:15];
            d_rs2 = head_inst[24:20];
            imm32 = {{19{head_inst[31]}}, head_inst[31], head_inst[7], head_inst[30:25],
                     head_inst[11:8], 1'b0};
         end
         7'h0f: d_opc = OC_NOP;
         default: d_opc = OC_ILL;
      endcase
   end

   assign d_imm  = XLEN'($signed(imm32));
   // unused sources decode to x0, which is never pending
   assign hazard = pend[d_rs1] | pend[d_rs2];
   assign load   = head_valid && (!issue_valid_o || issue_ready_i) && !hazard && !flush_i;

`ifdef ID_JAL_REDIRECT_EN
   assign jal_redir = load && (d_opc == OC_JAL);
`else
   assign jal_redir = 1'b0;
`endif

   assign push = inst_valid_i && inst_ready_o && !flush_i && !jal_redir;

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (load && d_opc == OC_LOAD && d_rd != '0) set_mask[d_rd] = 1'b1;
      if (ld_done_i) clr_mask[ld_done_addr_i] = 1'b1;
      if (flush_i && issue_valid_o && !issue_ready_i && opclass_o == OC_LOAD) clr_mask[rd_o] = 1'b1;
      pend_next    = (pend & ~clr_mask) | set_mask;
      pend_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_inst[wr_ptr] <= inst_i;
         q_pc[wr_ptr]   <= pc_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count_o       <= '0;
         pend          <= '0;
         issue_valid_o <= 1'b0;
         opclass_o     <= '0;
         funct3_o      <= '0;
         alt_o         <= 1'b0;
         rs1_o         <= '0;
         rs2_o         <= '0;
         rd_o          <= '0;
         wreg_o        <= 1'b0;
         imm_o         <= '0;
         pc_o          <= '0;
      end else begin
         pend <= pend_next;
         if (flush_i) begin
            rd_ptr        <= wr_ptr;
            count_o       <= '0;
            issue_valid_o <= 1'b0;
         end else begin
            if (jal_redir) begin
               rd_ptr  <= wr_ptr;
               count_o <= '0;
            end else begin
               if (push) wr_ptr <= wr_ptr + PTR_ONE;
               if (load) rd_ptr <= rd_ptr + PTR_ONE;
               if (push && !load)      count_o <= count_o + CNT_ONE;
               else if (!push && load) count_o <= count_o - CNT_ONE;
            end
            if (load) begin
               issue_valid_o <= 1'b1;
               opclass_o     <= d_opc;
               funct3_o      <= head_inst[14:12];
               alt_o         <= head_inst[30];
               rs1_o         <= d_rs1;
               rs2_o         <= d_rs2;
               rd_o          <= d_rd;
               wreg_o        <= (d_rd != '0);
               imm_o         <= d_imm;
               pc_o          <= head_pc;
            end else if (issue_ready_i) begin
               issue_valid_o <= 1'b0;
            end
         end
      end
   end

`ifdef ID_JAL_REDIRECT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         redirect_valid_o <= 1'b0;
         redirect_pc_o    <= '0;
      end else begin
         redirect_valid_o <= jal_redir;
         if (jal_redir) redirect_pc_o <= head_pc + d_imm;
      end
   end
`else
   assign redirect_valid_o = 1'b0;
   assign redirect_pc_o    = '0;
`endif

endmodule

// File: tb/tb_id_issue_queue.sv
// Self-checking bench for id_issue_queue; expected issue records are queued at push time and popped at issue.
module tb_id_issue_queue;

   typedef struct packed {
      logic [3:0]  opc;
      logic [2:0]  f3;
      logic        alt;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        wreg;
      logic [31:0] imm;
      logic [31:0] pc;
   } iss_t;

   logic        clk = 1'b0;
   logic        rst, inst_valid_i, flush_i, ld_done_i, issue_ready_i;
   logic [31:0] inst_i, pc_i;
   logic [4:0]  ld_done_addr_i;
   logic        inst_ready_o, issue_valid_o, alt_o, wreg_o, redirect_valid_o;
   logic [3:0]  opclass_o;
   logic [2:0]  funct3_o;
   logic [4:0]  rs1_o, rs2_o, rd_o;
   logic [31:0] imm_o, pc_o, redirect_pc_o;
   logic [2:0]  count_o;

   int checks = 0;
   int errors = 0;
   iss_t sb[$];
   iss_t obs;

   assign obs = {opclass_o, funct3_o, alt_o, rs1_o, rs2_o, rd_o, wreg_o, imm_o, pc_o};

   always #5 clk = ~clk;

   id_issue_queue #(.XLEN(32), .DEPTH(4), .NREG(32)) dut (
      .clk(clk), .rst(rst), .inst_valid_i(inst_valid_i), .inst_i(inst_i), .pc_i(pc_i),
      .inst_ready_o(inst_ready_o), .flush_i(flush_i), .ld_done_i(ld_done_i),
      .ld_done_addr_i(ld_done_addr_i), .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
      .opclass_o(opclass_o), .funct3_o(funct3_o), .alt_o(alt_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
      .rd_o(rd_o), .wreg_o(wreg_o), .imm_o(imm_o), .pc_o(pc_o), .count_o(count_o),
      .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
   );

   function automatic iss_t mk(input logic [3:0] opc, input logic [2:0] f3, input logic alt,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic wreg, input logic [31:0] imm, input logic [31:0] pc);
      return {opc, f3, alt, rs1, rs2, rd, wreg, imm, pc};
   endfunction

   function automatic logic [31:0] f_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
      return {imm, rs1, 3'b000, rd, 7'h13};
   endfunction

   function automatic logic [31:0] f_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'd0, rs2, rs1, 3'b000, rd, 7'h33};
   endfunction

   function automatic logic [31:0] f_lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
      return {imm, rs1, 3'b010, rd, 7'h03};
   endfunction

   function automatic logic [31:0] f_jal(input logic [4:0] rd, input logic [20:0] off);
      return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6f};
   endfunction

   function automatic iss_t pop_exp();
      iss_t e = '0;
      if (sb.size() > 0) e = sb.pop_front();
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
      inst_valid_i = 1'b1;
      inst_i       = ins;
      pc_i         = pc;
   endtask

   task automatic test_reset();
      rst = 1'b1; inst_valid_i = 1'b0; flush_i = 1'b0; ld_done_i = 1'b0; issue_ready_i = 1'b0;
      inst_i = '0; pc_i = '0; ld_done_addr_i = '0;
      step(); step();
      rst = 1'b0;
      checks++;
      if (issue_valid_o !== 1'b0 || count_o !== 3'd0 || inst_ready_o !== 1'b1 ||
          redirect_valid_o !== 1'b0 || obs !== '0) begin
         errors++;
         $display("FAIL reset: valid=%b count=%0d ready=%b redir=%b outs=%h, need 0/0/1/0/0",
                  issue_valid_o, count_o, inst_ready_o, redirect_valid_o, obs);
      end
   endtask

   task automatic test_basic();
      iss_t e;
      issue_ready_i = 1'b1;
      drive(f_addi(5'd1, 5'd0, 12'd5), 32'h100);
      sb.push_back(mk(4'd3, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 1'b1, 32'd5, 32'h100));
      step();
      inst_valid_i = 1'b0;
      checks++;
      if (issue_valid_o !== 1'b0 || count_o !== 3'd1) begin
         errors++;
         $display("FAIL basic_latency: valid=%b count=%0d, need 0/1", issue_valid_o, count_o);
      end
      step();
      e = pop_exp();
      checks++;
      if (issue_valid_o !== 1'b1 || obs !== e) begin
         errors++;
         $display("FAIL basic_issue: valid=%b got %h need %h", issue_valid_o, obs, e);
      end
      step();
      checks++;
      if (issue_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL basic_drain: valid=%b need 0", issue_valid_o);
      end
   endtask

   task automatic test_decode();
      logic [31:0] ins [7];
      iss_t ex [6];
      iss_t e;
      int n = 0;
      ins[0] = f_addi(5'd1, 5'd0, 12'hFFF);
      ex[0]  = mk(4'd3, 3'd0, 1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 32'hFFFF_FFFF, 32'h500);
      ins[1] = {7'b0100000, 5'd3, 5'd4, 3'b101, 5'd3, 7'h13};
      ex[1]  = mk(4'd3, 3'd5, 1'b1, 5'd4, 5'd0, 5'd3, 1'b1, 32'd3, 32'h504);
      ins[2] = {7'd0, 5'd6, 5'd2, 3'b010, 5'd12, 7'h23};
      ex[2]  = mk(4'd6, 3'd2, 1'b0, 5'd2, 5'd6, 5'd0, 1'b0, 32'd12, 32'h508);
      ins[3] = {1'b1, 6'b111111, 5'd2, 5'd1, 3'b000, 4'b1100, 1'b1, 7'h63};
      ex[3]  = mk(4'd9, 3'd0, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 32'hFFFF_FFF8, 32'h50c);
      ins[4] = {20'h12345, 5'd7, 7'h37};
      ex[4]  = mk(4'd1, 3'd5, 1'b0, 5'd0, 5'd0, 5'd7, 1'b1, 32'h1234_5000, 32'h510);
      ins[5] = {12'd16, 5'd5, 3'b000, 5'd1, 7'h67};
      ex[5]  = mk(4'd8, 3'd0, 1'b0, 5'd5, 5'd0, 5'd1, 1'b1, 32'd16, 32'h514);
      ins[6] = 32'hFFFF_FFFF;
      issue_ready_i = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (c < 7) begin
            drive(ins[c], 32'h500 + 32'(4 * c));
            if (c < 6) sb.push_back(ex[c]);
         end else begin
            inst_valid_i = 1'b0;
         end
         step();
         if (issue_valid_o) begin
            n++;
            checks++;
            if (sb.size() > 0) begin
               e = pop_exp();
               if (obs !== e) begin
                  errors++;
                  $display("FAIL decode_%0d: got %h need %h", n, obs, e);
               end
            end else if (opclass_o !== 4'hF || rs1_o !== 5'd0 || rs2_o !== 5'd0 ||
                         wreg_o !== 1'b0 || imm_o !== 32'd0) begin
               errors++;
               $display("FAIL decode_illegal: opc=%0d rs1=%0d rs2=%0d wreg=%b imm=%h, need 15/0/0/0/0",
                        opclass_o, rs1_o, rs2_o, wreg_o, imm_o);
            end
         end
      end
      checks++;
      if (n != 7) begin
         errors++;
         $display("FAIL decode_count: issued %0d need 7", n);
      end
   endtask

   task automatic test_full();
      iss_t e;
      int n = 0;
      issue_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(f_addi(5'(10 + i), 5'd0, 12'(i + 1)), 32'h300 + 32'(4 * i));
         sb.push_back(mk(4'd3, 3'd0, 1'b0, 5'd0, 5'd0, 5'(10 + i), 1'b1, 32'(i + 1), 32'h300 + 32'(4 * i)));
         step();
      end
      checks++;
      if (count_o !== 3'd4 || inst_ready_o !== 1'b0 || issue_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL full_state: count=%0d ready=%b valid=%b, need 4/0/1", count_o, inst_ready_o, issue_valid_o);
      end
      drive(f_addi(5'd20, 5'd0, 12'd99), 32'h3f0);
      step();
      inst_valid_i = 1'b0;
      checks++;
      if (count_o !== 3'd4) begin
         errors++;
         $display("FAIL full_no_push: count=%0d need 4", count_o);
      end
      issue_ready_i = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (issue_valid_o) begin
            n++;
            e = pop_exp();
            checks++;
            if (obs !== e) begin
               errors++;
               $display("FAIL full_order_%0d: got %h need %h", n, obs, e);
            end
         end
         step();
      end
      checks++;
      if (n != 5 || count_o !== 3'd0 || issue_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL full_drain: issued=%0d count=%0d valid=%b, need 5/0/0", n, count_o, issue_valid_o);
      end
   endtask

   task automatic test_hazard();
      iss_t e;
      issue_ready_i = 1'b1;
      drive(f_lw(5'd5, 5'd0, 12'd8), 32'h700);
      sb.push_back(mk(4'd5, 3'd2, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 32'd8, 32'h700));
      step();
      drive(f_add(5'd6, 5'd5, 5'd7), 32'h704);
      sb.push_back(mk(4'd4, 3'd0, 1'b0, 5'd5, 5'd7, 5'd6, 1'b1, 32'd0, 32'h704));
      step();
      inst_valid_i = 1'b0;
      e = pop_exp();
      checks++;
      if (issue_valid_o !== 1'b1 || obs !== e) begin
         errors++;
         $display("FAIL hazard_lw: valid=%b got %h need %h", issue_valid_o, obs, e);
      end
      step(); step(); step();
      checks++;
      if (issue_valid_o !== 1'b0 || count_o !== 3'd1) begin
         errors++;
         $display("FAIL hazard_stall: valid=%b count=%0d, need 0/1", issue_valid_o, count_o);
      end
      ld_done_i = 1'b1; ld_done_addr_i = 5'd5;
      step();
      ld_done_i = 1'b0;
      checks++;
      if (issue_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL hazard_same_cycle: valid=%b need 0", issue_valid_o);
      end
      step();
      e = pop_exp();
      checks++;
      if (issue_valid_o !== 1'b1 || obs !== e) begin
         errors++;
         $display("FAIL hazard_release: valid=%b got %h need %h", issue_valid_o, obs, e);
      end
      step();
      // rd=x0 load must not create a dependency for an x0 source
      drive(f_lw(5'd0, 5'd0, 12'd4), 32'h710);
      sb.push_back(mk(4'd5, 3'd2, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd4, 32'h710));
      step();
      drive(f_add(5'd9, 5'd0, 5'd0), 32'h714);
      sb.push_back(mk(4'd4, 3'd0, 1'b0, 5'd0, 5'd0, 5'd9, 1'b1, 32'd0, 32'h714));
      step();
      inst_valid_i = 1'b0;
      e = pop_exp();
      checks++;
      if (issue_valid_o !== 1'b1 || obs !== e) begin
         errors++;
         $display("FAIL x0_lw: valid=%b got %h need %h", issue_valid_o, obs, e);
      end
      step();
      e = pop_exp();
      checks++;
      if (issue_valid_o !== 1'b1 || obs !== e) begin
         errors++;
         $display("FAIL x0_no_stall: valid=%b got %h need %h", issue_valid_o, obs, e);
      end
      step();
   endtask

   task automatic test_set_clear();
      iss_t e;
      issue_ready_i = 1'b1;
      drive(f_lw(5'd9, 5'd0, 12'd0), 32'h600);
      sb.push_back(mk(4'd5, 3'd2, 1'b0, 5'd0, 5'd0, 5'd9, 1'b1, 32'd0, 32'h600));
      step();
      ld_done_i = 1'b1; ld_done_addr_i = 5'd9;
      drive(f_add(5'd10, 5'd9, 5'd0), 32'h604);
      sb.push_back(mk(4'd4, 3'd0, 1'b0, 5'd9, 5'd0, 5'd10, 1'b1, 32'd0, 32'h604));
      step();
      ld_done_i = 1'b0; inst_valid_i = 1'b0;
      e = pop_exp();
      checks++;
      if (issue_valid_o !== 1'b1 || obs !== e) begin
         errors++;
         $display("FAIL setclr_lw: valid=%b got %h need %h", issue_valid_o, obs, e);
      end
      step(); step(); step();
      checks++;
      if (issue_valid_o !== 1'b0 || count_o !== 3'd1) begin
         errors++;
         $display("FAIL setclr_set_wins: valid=%b count=%0d, need 0/1", issue_valid_o, count_o);
      end
      ld_done_i = 1'b1; ld_done_addr_i = 5'd9;
      step();
      ld_done_i = 1'b0;
      step();
      e = pop_exp();
      checks++;
      if (issue_valid_o !== 1'b1 || obs !== e) begin
         errors++;
         $display("FAIL setclr_release: valid=%b got %h need %h", issue_valid_o, obs, e);
      end
      step();
   endtask

   task automatic test_flush();
      iss_t e;
      issue_ready_i = 1'b0;
      drive(f_lw(5'd3, 5'd0, 12'd0), 32'h400);
      sb.push_back(mk(4'd5, 3'd2, 1'b0, 5'd0, 5'd0, 5'd3, 1'b1, 32'd0, 32'h400));
      step();
      drive(f_addi(5'd11, 5'd0, 12'd1), 32'h404);
      step();
      inst_valid_i = 1'b0;
      e = pop_exp();
      checks++;
      if (issue_valid_o !== 1'b1 || obs !== e) begin
         errors++;
         $display("FAIL flush_lw: valid=%b got %h need %h", issue_valid_o, obs, e);
      end
      step(); step();
      checks++;
      if (issue_valid_o !== 1'b1 || obs !== e || count_o !== 3'd1) begin
         errors++;
         $display("FAIL flush_hold_stable: valid=%b count=%0d got %h need %h", issue_valid_o, count_o, obs, e);
      end
      flush_i = 1'b1;
      drive(f_addi(5'd12, 5'd0, 12'd2), 32'h408);
      step();
      flush_i = 1'b0; inst_valid_i = 1'b0;
      checks++;
      if (issue_valid_o !== 1'b0 || count_o !== 3'd0) begin
         errors++;
         $display("FAIL flush_empty: valid=%b count=%0d, need 0/0", issue_valid_o, count_o);
      end
      issue_ready_i = 1'b1;
      drive(f_add(5'd4, 5'd3, 5'd3), 32'h410);
      sb.push_back(mk(4'd4, 3'd0, 1'b0, 5'd3, 5'd3, 5'd4, 1'b1, 32'd0, 32'h410));
      step();
      inst_valid_i = 1'b0;
      step();
      e = pop_exp();
      checks++;
      if (issue_valid_o !== 1'b1 || obs !== e) begin
         errors++;
         $display("FAIL flush_pend_cleared: valid=%b got %h need %h", issue_valid_o, obs, e);
      end
      step();
   endtask

   task automatic test_jal();
      iss_t e;
      int n = 0;
      issue_ready_i = 1'b0;
      drive(f_addi(5'd2, 5'd0, 12'd7), 32'h1fc);
      sb.push_back(mk(4'd3, 3'd0, 1'b0, 5'd0, 5'd0, 5'd2, 1'b1, 32'd7, 32'h1fc));
      step();
      drive(f_jal(5'd1, 21'h20), 32'h200);
      sb.push_back(mk(4'd7, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 1'b1, 32'h20, 32'h200));
      step();
      drive(f_addi(5'd20, 5'd0, 12'd1), 32'h204);
      step();
      drive(f_addi(5'd21, 5'd0, 12'd2), 32'h208);
      step();
      inst_valid_i = 1'b0;
      e = pop_exp();
      checks++;
      if (issue_valid_o !== 1'b1 || obs !== e || count_o !== 3'd3) begin
         errors++;
         $display("FAIL jal_setup: valid=%b count=%0d got %h need %h", issue_valid_o, count_o, obs, e);
      end
      issue_ready_i = 1'b1;
      step();
      e = pop_exp();
      checks++;
      if (issue_valid_o !== 1'b1 || obs !== e) begin
         errors++;
         $display("FAIL jal_issue: valid=%b got %h need %h", issue_valid_o, obs, e);
      end
`ifdef ID_JAL_REDIRECT_EN
      checks++;
      if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h220 || count_o !== 3'd0) begin
         errors++;
         $display("FAIL jal_redirect: redir=%b pc=%h count=%0d, need 1/220/0", redirect_valid_o, redirect_pc_o, count_o);
      end
      step();
      checks++;
      if (redirect_valid_o !== 1'b0 || issue_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL jal_pulse: redir=%b valid=%b, need 0/0", redirect_valid_o, issue_valid_o);
      end
`else
      sb.push_back(mk(4'd3, 3'd0, 1'b0, 5'd0, 5'd0, 5'd20, 1'b1, 32'd1, 32'h204));
      sb.push_back(mk(4'd3, 3'd0, 1'b0, 5'd0, 5'd0, 5'd21, 1'b1, 32'd2, 32'h208));
      checks++;
      if (redirect_valid_o !== 1'b0 || redirect_pc_o !== 32'd0 || count_o !== 3'd2) begin
         errors++;
         $display("FAIL jal_no_redirect: redir=%b pc=%h count=%0d, need 0/0/2", redirect_valid_o, redirect_pc_o, count_o);
      end
      step();
      for (int c = 0; c < 8; c++) begin
         if (issue_valid_o) begin
            n++;
            e = pop_exp();
            checks++;
            if (obs !== e) begin
               errors++;
               $display("FAIL jal_younger_%0d: got %h need %h", n, obs, e);
            end
         end
         step();
      end
      checks++;
      if (n != 2) begin
         errors++;
         $display("FAIL jal_younger_count: issued %0d need 2", n);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_decode();
      test_full();
      test_hazard();
      test_set_clear();
      test_flush();
      test_jal();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover: %0d entries need 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
